// File: rtl/fmc_i2c_byte_ctrl_if.sv
// rtl/fmc_i2c_byte_ctrl_if.sv - command/response handshake and I2C pad bundle for fmc_i2c_byte_ctrl
interface fmc_i2c_byte_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_rd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_err;
    logic       busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_t;
    logic       sda_t;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata, cmd_rd_nack, scl_i, sda_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err, busy, scl_t, sda_t
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata, cmd_rd_nack, scl_i, sda_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err, busy, scl_t, sda_t
    );
endinterface

// File: rtl/fmc_i2c_byte_ctrl.sv
// rtl/fmc_i2c_byte_ctrl.sv - byte-level I2C master sequencer (START/WRITE/READ/STOP), SCL stretching under I2C_CLK_STRETCH_EN
module fmc_i2c_byte_ctrl #(
    parameter int QTR_DIV = 97
) (
    input  logic               CLK,
    input  logic               RST_N,
    fmc_i2c_byte_ctrl_if.slave bus
);
    localparam int            TW   = $clog2(QTR_DIV + 1);
    localparam logic [TW-1:0] TMAX = TW'(QTR_DIV - 1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_ERR,
        ST_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [1:0]    phase;
    logic [3:0]    bit_cnt;
    logic [1:0]    op;
    logic [7:0]    wdata;
    logic          rd_nack;
    logic          bus_owned;
    logic          owned_nxt;
    logic          scl_t_r;
    logic          sda_t_r;
    logic          scl_nxt;
    logic          sda_nxt;
    logic [7:0]    shreg;
    logic [7:0]    rdata_r;
    logic          ack_r;
    logic          in_op;
    logic          hold;
    logic          qtick;
    logic          accept;
    logic [3:0]    nbit;
    logic [7:0]    wshift;
    logic          nbit_sda;

    assign in_op  = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);
    assign accept = bus.cmd_valid && (state == ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
    // SCL is released during q1/q2; a slave holding it low freezes the quarter
    assign hold = in_op && ((phase == 2'd1) || (phase == 2'd2)) && !bus.scl_i;
`else
    assign hold = 1'b0;
`endif

    assign qtick = in_op && !hold && (timer == TMAX);

    // SDA value for the bit that starts at the next q0
    always_comb begin
        nbit     = bit_cnt + 4'd1;
        wshift   = wdata << nbit;
        nbit_sda = 1'b1;
        if (nbit == 4'd8) begin
            nbit_sda = (op == OP_WRITE) ? 1'b1 : rd_nack;
        end else if (op == OP_WRITE) begin
            nbit_sda = wshift[7];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_nxt   = scl_t_r;
        sda_nxt   = sda_t_r;
        owned_nxt = bus_owned;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_START: begin
                            state_nxt = ST_START;
                            sda_nxt   = 1'b1;
                        end
                        OP_WRITE, OP_READ: begin
                            if (bus_owned) begin
                                state_nxt = ST_BIT;
                                sda_nxt   = (bus.cmd_op == OP_WRITE) ? bus.cmd_wdata[7] : 1'b1;
                            end else begin
                                state_nxt = ST_ERR;
                            end
                        end
                        default: begin
                            if (bus_owned) begin
                                state_nxt = ST_STOP;
                                sda_nxt   = 1'b0;
                            end else begin
                                state_nxt = ST_ERR;
                            end
                        end
                    endcase
                end
            end
            ST_START: begin
                if (qtick) begin
                    case (phase)
                        2'd0: scl_nxt = 1'b1;
                        2'd1: sda_nxt = 1'b0;
                        2'd2: scl_nxt = 1'b0;
                        default: begin
                            state_nxt = ST_RESP;
                            owned_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_BIT: begin
                if (qtick) begin
                    case (phase)
                        2'd0: scl_nxt = 1'b1;
                        2'd2: scl_nxt = 1'b0;
                        2'd3: begin
                            if (bit_cnt == 4'd8) begin
                                state_nxt = ST_RESP;
                            end else begin
                                sda_nxt = nbit_sda;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_STOP: begin
                if (qtick) begin
                    case (phase)
                        2'd0: scl_nxt = 1'b1;
                        2'd1: sda_nxt = 1'b1;
                        2'd3: begin
                            state_nxt = ST_RESP;
                            owned_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ERR:  state_nxt = ST_IDLE;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer     <= '0;
            phase     <= 2'd0;
            bit_cnt   <= 4'd0;
            op        <= 2'd0;
            wdata     <= 8'd0;
            rd_nack   <= 1'b0;
            bus_owned <= 1'b0;
            scl_t_r   <= 1'b1;
            sda_t_r   <= 1'b1;
            shreg     <= 8'd0;
            rdata_r   <= 8'd0;
            ack_r     <= 1'b0;
        end else begin
            scl_t_r   <= scl_nxt;
            sda_t_r   <= sda_nxt;
            bus_owned <= owned_nxt;
            if (accept) begin
                op      <= bus.cmd_op;
                wdata   <= bus.cmd_wdata;
                rd_nack <= bus.cmd_rd_nack;
            end
            if (!in_op) begin
                timer <= '0;
            end else if (!hold) begin
                timer <= (timer == TMAX) ? '0 : timer + 1'b1;
            end
            if (!in_op) begin
                phase <= 2'd0;
            end else if (qtick) begin
                phase <= phase + 2'd1;
            end
            if (!in_op) begin
                bit_cnt <= 4'd0;
            end else if ((state == ST_BIT) && qtick && (phase == 2'd3) && (bit_cnt != 4'd8)) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            // SDA is sampled at the end of q2, just before SCL is pulled low again
            if ((state == ST_BIT) && qtick && (phase == 2'd2)) begin
                if (bit_cnt == 4'd8) begin
                    ack_r <= bus.sda_i;
                end else begin
                    shreg <= {shreg[6:0], bus.sda_i};
                end
            end
            if ((state == ST_BIT) && qtick && (phase == 2'd3) && (bit_cnt == 4'd8) && (op == OP_READ)) begin
                rdata_r <= shreg;
            end
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP) || (state == ST_ERR);
    assign bus.rsp_err   = (state == ST_ERR);
    assign bus.rsp_nack  = (state == ST_RESP) && (op == OP_WRITE) && ack_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.scl_t     = scl_t_r;
    assign bus.sda_t     = sda_t_r;
endmodule

// File: tb/tb_fmc_i2c_byte_ctrl.sv
// tb/tb_fmc_i2c_byte_ctrl.sv - randomized bench for fmc_i2c_byte_ctrl against a transaction-level I2C bus model
`timescale 1ns/1ps
module tb_fmc_i2c_byte_ctrl;
    localparam int QTR        = 97;
    localparam int BIT_PERIOD = 4 * QTR;
    localparam int LAT_SHORT  = 4 * QTR + 1;
    localparam int LAT_BYTE   = 36 * QTR + 1;

    logic CLK = 1'b0;
    logic RST_N;
    always #3.2 CLK = ~CLK;

    fmc_i2c_byte_ctrl_if bus();

    fmc_i2c_byte_ctrl #(.QTR_DIV(QTR)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // open-drain bus: a line is high only when nobody pulls it low
    logic       stretch_low = 1'b0;
    logic       slave_on    = 1'b0;
    logic [8:0] slave_bits  = '1;
    int         idx         = 0;
    logic       sda_slave;
    logic       scl_bus;
    logic       sda_bus;
    assign sda_slave = (slave_on && idx < 9) ? slave_bits[idx] : 1'b1;
    assign scl_bus   = bus.scl_t & ~stretch_low;
    assign sda_bus   = bus.sda_t & sda_slave;
    assign bus.scl_i = scl_bus;
    assign bus.sda_i = sda_bus;

    int   cyc = 0, starts = 0, stops = 0, toggles = 0, stretch_rem = 0;
    int   rises[$];
    logic bits_q[$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_st = 1'b1, prev_dt = 1'b1;
    logic stretch_arm = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (prev_scl && scl_bus) begin
            if (prev_sda && !sda_bus) starts++;
            if (!prev_sda && sda_bus) stops++;
        end
        if (!prev_scl && scl_bus) begin
            rises.push_back(cyc);
            bits_q.push_back(sda_bus);
        end
        if (prev_scl && !scl_bus && slave_on) idx++;
        if (bus.scl_t !== prev_st || bus.sda_t !== prev_dt) toggles++;
        prev_scl = scl_bus;
        prev_sda = sda_bus;
        prev_st  = bus.scl_t;
        prev_dt  = bus.sda_t;
        if (stretch_low) begin
            if (bus.scl_t) begin
                if (stretch_rem == 0) stretch_low = 1'b0;
                else stretch_rem--;
            end
        end else if (stretch_arm && slave_on && idx == 3) begin
            stretch_low = 1'b1;
            stretch_arm = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    bit         exp_owned = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input logic rdn, input logic ack_present, input logic [7:0] sbyte,
                           input int extra, input bit inject);
        bit         err;
        bit         is_byte;
        int         exp_lat;
        int         n;
        int         busy_low;
        logic [8:0] exp_bits;
        logic [8:0] got_bits;
        err     = (op != 2'd0) && !exp_owned;
        is_byte = (op == 2'd1) || (op == 2'd2);
        exp_lat = err ? 1 : (is_byte ? LAT_BYTE + extra : LAT_SHORT);
        @(posedge CLK); #1;
        rises.delete();
        bits_q.delete();
        starts   = 0;
        stops    = 0;
        toggles  = 0;
        idx      = 0;
        slave_on = !err && is_byte;
        if (op == 2'd1) begin
            slave_bits = {~ack_present, 8'hFF};
        end else begin
            for (int k = 0; k < 8; k++) slave_bits[k] = sbyte[7-k];
            slave_bits[8] = 1'b1;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_wdata   = data;
        bus.cmd_rd_nack = rdn;
        @(negedge CLK);
        chk($sformatf("%s_ready", tag), 32'(bus.cmd_ready), 32'd1);
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 8'($urandom);
        n        = 0;
        busy_low = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!bus.busy) busy_low++;
            if (inject && !err && n == 5) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'($urandom);
            end
            if (inject && !err && n == 6) bus.cmd_valid = 1'b0;
        end while (!bus.rsp_valid && n < exp_lat + 1000);
        if (op == 2'd2 && !err) exp_rdata = sbyte;
        chk($sformatf("%s_lat", tag), 32'(n), 32'(exp_lat));
        chk($sformatf("%s_err", tag), 32'(bus.rsp_err), 32'(err));
        chk($sformatf("%s_nack", tag), 32'(bus.rsp_nack), 32'(op == 2'd1 && !err && !ack_present));
        chk($sformatf("%s_rdata", tag), 32'(bus.rsp_rdata), 32'(exp_rdata));
        chk($sformatf("%s_busy", tag), 32'(busy_low), 32'd0);
        @(negedge CLK);
        chk($sformatf("%s_idle", tag), {29'd0, bus.cmd_ready, bus.busy, bus.rsp_valid}, 32'd4);
        slave_on = 1'b0;
        if (is_byte && !err) begin
            exp_bits = (op == 2'd1) ? {data, ~ack_present} : {sbyte, rdn};
            got_bits = '0;
            foreach (bits_q[k]) got_bits = {got_bits[7:0], bits_q[k]};
            chk($sformatf("%s_nbits", tag), 32'(bits_q.size()), 32'd9);
            chk($sformatf("%s_bits", tag), 32'(got_bits), 32'(exp_bits));
            if (extra == 0 && rises.size() == 9) begin
                chk($sformatf("%s_period", tag), 32'(rises[1] - rises[0]), 32'(BIT_PERIOD));
                chk($sformatf("%s_span", tag), 32'(rises[8] - rises[0]), 32'(8 * BIT_PERIOD));
            end
        end
        chk($sformatf("%s_starts", tag), 32'(starts), 32'(op == 2'd0));
        chk($sformatf("%s_stops", tag), 32'(stops), 32'(op == 2'd3 && !err));
        if (err) chk($sformatf("%s_quiet", tag), 32'(toggles), 32'd0);
        if (op == 2'd3 && !err) chk($sformatf("%s_lines", tag), {30'd0, bus.scl_t, bus.sda_t}, 32'd3);
        if (op == 2'd0) exp_owned = 1'b1;
        if (op == 2'd3 && !err) exp_owned = 1'b0;
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'd0;
        bus.cmd_wdata   = 8'd0;
        bus.cmd_rd_nack = 1'b0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_lines", {30'd0, bus.scl_t, bus.sda_t}, 32'd3);
        chk("rst_hs", {28'd0, bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_err}, 32'd8);
        chk("rst_rsp", {23'd0, bus.rsp_nack, bus.rsp_rdata}, 32'd0);
        @(negedge CLK) RST_N = 1'b1;

        run_cmd("start", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        run_cmd("wr_a4", 2'd1, 8'hA4, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        run_cmd("wr_5a", 2'd1, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        run_cmd("rd_3c", 2'd2, 8'h00, 1'b1, 1'b0, 8'h3C, 0, 1'b0);
        run_cmd("stop", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);

        // reset in quarter 10 of a WRITE of 0x00: SDA is being driven low with SCL high
        run_cmd("start2", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        @(posedge CLK); #1;
        idx           = 0;
        slave_bits    = '1;
        slave_on      = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_wdata = 8'h00;
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        repeat (10 * QTR + 40) @(posedge CLK);
        #2;
        chk("mid_lines", {30'd0, bus.scl_t, bus.sda_t}, 32'd2);
        RST_N = 1'b0;
        #1;
        chk("arst_lines", {30'd0, bus.scl_t, bus.sda_t}, 32'd3);
        chk("arst_hs", {30'd0, bus.cmd_ready, bus.busy}, 32'd2);
        @(negedge CLK);
        RST_N     = 1'b1;
        slave_on  = 1'b0;
        exp_owned = 1'b0;
        exp_rdata = 8'h00;
        run_cmd("err_wr", 2'd1, 8'h55, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        run_cmd("err_rd", 2'd2, 8'h00, 1'b0, 1'b0, 8'h99, 0, 1'b0);
        run_cmd("err_sp", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
        run_cmd("st_start", 2'd0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        stretch_rem = 500;
        stretch_arm = 1'b1;
        run_cmd("st_wr", 2'd1, 8'hC3, 1'b0, 1'b1, 8'h00, 500, 1'b0);
        run_cmd("st_stop", 2'd3, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0);
`endif

        for (int i = 0; i < 14; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            if (!exp_owned && $urandom_range(0, 1) == 1) rop = 2'd0;
            run_cmd($sformatf("rnd%0d", i), rop, 8'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
